fetch_entry_queue: RTL



---
 rtl/fetch_entry_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_entry_queue.sv
// Fetch entry queue: a small circular buffer that sits between the frontend
// fetch output and the decode stage. Entries are held here until decode takes
// them. Once an exception entry has been accepted, no further entries are
// taken until a flush. A flush empties the queue in a single cycle.

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32};
endpackage

package ariane_pkg;
    typedef struct packed {
        logic [2:0]  cf;
        logic [31:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [31:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;
endpackage

module fetch_entry_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  ariane_pkg::fetch_entry_t     fetch_entry_i,
    input  logic                         fetch_entry_valid_i,
    output logic                         fetch_entry_ready_o,
    output ariane_pkg::fetch_entry_t     fetch_entry_o,
    output logic                         fetch_entry_valid_o,
    input  logic                         fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]       usage_o,
    output logic                         ex_lock_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage is never reset; only the pointers and counter say what is live.
    ariane_pkg::fetch_entry_t r_mem [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_usage;
    logic             r_ex_lock;

    logic w_full;
    logic w_push;
    logic w_pop;

    // Handshake decode. Readiness never looks at the incoming valid, so the
    // frontend can compute its valid from our ready without a loop. A full
    // queue stays unready even while it is being popped; the freed slot is
    // offered on the following cycle.
    always_comb begin
        w_full              = (r_usage == CNT_W'(DEPTH));
        fetch_entry_ready_o = !w_full && !r_ex_lock && !flush_i;
        fetch_entry_valid_o = (r_usage != '0);
        w_push              = fetch_entry_valid_i && fetch_entry_ready_o;
        w_pop               = fetch_entry_valid_o && fetch_entry_ready_i;
        fetch_entry_o       = r_mem[r_rd_ptr];
        usage_o             = r_usage;
        ex_lock_o           = r_ex_lock;
    end

    // Write the accepted entry at the write pointer (no fall-through to the output).
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fetch_entry_i;
        end
    end

    // Pointers, occupancy and the exception lock; a flush clears all of them at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_usage   <= '0;
            r_ex_lock <= 1'b0;
        end else if (flush_i) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_usage   <= '0;
            r_ex_lock <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (fetch_entry_i.ex.valid) begin
                    r_ex_lock <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_usage <= r_usage + CNT_W'(1);
                2'b01:   r_usage <= r_usage - CNT_W'(1);
                default: r_usage <= r_usage;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Pointer wrap-around relies on DEPTH being a power of two.
    a_depth_pow2: assert property (@(posedge clk_i)
        (DEPTH >= 2) && (DEPTH == (1 << PTR_W)) && (CVA6Cfg.XLEN != 0));

    // A full queue must never accept an entry.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && w_full));

    // Occupancy can never exceed the number of slots.
    a_usage_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_usage <= CNT_W'(DEPTH));
`endif

endmodule
